// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss.cc stopwatch: FSM encoding, BCD digit
// width and maxima, and the field layout of the display word.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_t;

    localparam int DIGIT_W  = 4;
    localparam int ONES_MAX = 9;
    localparam int TENS_MAX = 5;
    localparam int DISP_W   = 6 * DIGIT_W;

    localparam int CS_O_LSB  = 0;
    localparam int CS_T_LSB  = 4;
    localparam int SEC_O_LSB = 8;
    localparam int SEC_T_LSB = 12;
    localparam int MIN_O_LSB = 16;
    localparam int MIN_T_LSB = 20;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single mod-(MAX+1) BCD digit with synchronous clear and ripple carry out.
// Out-of-range values (MAX+1..15) wrap to 0 on the next increment.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = ONES_MAX
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out
);

    localparam logic [DIGIT_W-1:0] MAX_Q = DIGIT_W'(MAX);

    logic [DIGIT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            if (cnt >= MAX_Q) cnt <= '0;
            else              cnt <= cnt + DIGIT_W'(1);
        end
    end

    assign q         = cnt;
    assign carry_out = inc & (cnt == MAX_Q);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: FSM, centisecond prescaler and six-digit BCD chain.
// Lap snapshot support is built only when STOPWATCH_LAP_EN is defined.
//
// state | meaning
// IDLE  | stopped and zeroed, prescaler held at 0
// RUN   | counting, display shows live digits
// LAP   | counting, display frozen on snapshot
// PAUSE | stopped, digits and partial tick held
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_PER_TICK = 10,
    parameter int PRESC_W      = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              clear,
    output logic [DISP_W-1:0] disp_bcd,
    output logic              running,
    output logic              lap_active,
    output logic              overflow,
    output logic              tick
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_TICK - 1);

    sw_state_t          state, state_next;
    logic [PRESC_W-1:0] presc;
    logic               counting;
    logic               clear_all;
    logic               lap_capture;
    logic [DISP_W-1:0]  live;

    logic [DIGIT_W-1:0] cs_o, cs_t, sec_o, sec_t, min_o, min_t;
    logic               c_cs_o, c_cs_t, c_sec_o, c_sec_t, c_min_o, c_min_t;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // clear > start_stop > lap, but only among pulses legal in the current state
    always_comb begin
        state_next  = state;
        clear_all   = 1'b0;
        lap_capture = 1'b0;
        case (state)
            IDLE: begin
                if (start_stop) state_next = RUN;
            end
            RUN: begin
                if (start_stop) begin
                    state_next = PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (lap) begin
                    state_next  = LAP;
                    lap_capture = 1'b1;
`endif
                end
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (start_stop) state_next = PAUSE;
                else if (lap)   state_next = RUN;
            end
`endif
            PAUSE: begin
                if (clear) begin
                    state_next = IDLE;
                    clear_all  = 1'b1;
                end else if (start_stop) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n || state == IDLE) begin
            presc <= '0;
        end else if (counting) begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
        end
    end

    bcd_digit_counter #(.MAX(ONES_MAX)) u_cs_o (
        .clk(clk), .reset_n(reset_n), .clr(clear_all), .inc(tick),
        .q(cs_o), .carry_out(c_cs_o));
    bcd_digit_counter #(.MAX(ONES_MAX)) u_cs_t (
        .clk(clk), .reset_n(reset_n), .clr(clear_all), .inc(c_cs_o),
        .q(cs_t), .carry_out(c_cs_t));
    bcd_digit_counter #(.MAX(ONES_MAX)) u_sec_o (
        .clk(clk), .reset_n(reset_n), .clr(clear_all), .inc(c_cs_t),
        .q(sec_o), .carry_out(c_sec_o));
    bcd_digit_counter #(.MAX(TENS_MAX)) u_sec_t (
        .clk(clk), .reset_n(reset_n), .clr(clear_all), .inc(c_sec_o),
        .q(sec_t), .carry_out(c_sec_t));
    bcd_digit_counter #(.MAX(ONES_MAX)) u_min_o (
        .clk(clk), .reset_n(reset_n), .clr(clear_all), .inc(c_sec_t),
        .q(min_o), .carry_out(c_min_o));
    bcd_digit_counter #(.MAX(TENS_MAX)) u_min_t (
        .clk(clk), .reset_n(reset_n), .clr(clear_all), .inc(c_min_o),
        .q(min_t), .carry_out(c_min_t));

    always_comb begin
        live = '0;
        live[CS_O_LSB  +: DIGIT_W] = cs_o;
        live[CS_T_LSB  +: DIGIT_W] = cs_t;
        live[SEC_O_LSB +: DIGIT_W] = sec_o;
        live[SEC_T_LSB +: DIGIT_W] = sec_t;
        live[MIN_O_LSB +: DIGIT_W] = min_o;
        live[MIN_T_LSB +: DIGIT_W] = min_t;
    end

    // carry out of the top digit means we just wrapped past 59:59.99
    always_ff @(posedge clk) begin
        if (!reset_n || clear_all) overflow <= 1'b0;
        else if (c_min_t)          overflow <= 1'b1;
    end

    assign running = counting;

`ifdef STOPWATCH_LAP_EN
    logic [DISP_W-1:0] snapshot;

    always_ff @(posedge clk) begin
        if (!reset_n || clear_all) snapshot <= '0;
        else if (lap_capture)      snapshot <= live;
    end

    assign lap_active = (state == LAP);
    assign disp_bcd   = lap_active ? snapshot : live;
`else
    logic unused_lap;

    assign unused_lap = lap ^ lap_capture;
    assign lap_active = 1'b0;
    assign disp_bcd   = live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLK_PER_TICK=2; expectations are queued
// as stimulus is applied and popped when the outputs are sampled.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, start_stop, lap, clear;
    logic [23:0] disp_bcd;
    logic        running, lap_active, overflow, tick;

    int checks   = 0;
    int failures = 0;
    int ticks;
    int budget;

    logic [26:0] exp_q[$];
    string       tag_q[$];

    stopwatch_ctrl #(.CLK_PER_TICK(2), .PRESC_W(10)) dut (
        .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .lap(lap),
        .clear(clear), .disp_bcd(disp_bcd), .running(running),
        .lap_active(lap_active), .overflow(overflow), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] bcd_of(int cs);
        int c, m, s, h;
        c = cs % 360000;
        m = c / 6000;
        s = (c / 100) % 60;
        h = c % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    task automatic cmp(string tag, logic [23:0] obs, logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(string tag, logic [23:0] d, logic r, logic l, logic o);
        exp_q.push_back({d, r, l, o});
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [26:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            cmp("scoreboard_empty", 24'd0, 24'd1);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp({t, ".disp"},       disp_bcd,          e[26:3]);
        cmp({t, ".running"},    {23'd0, running},   {23'd0, e[2]});
        cmp({t, ".lap_active"}, {23'd0, lap_active},{23'd0, e[1]});
        cmp({t, ".overflow"},   {23'd0, overflow},  {23'd0, e[0]});
    endtask

    // called at a negedge; pulse is seen by exactly one rising edge
    task automatic pulse(logic ss, logic lp, logic cl);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        @(negedge clk);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        cycles(3);
        expect_out("reset", 24'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        cmp("reset.tick", {23'd0, tick}, 24'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            expect_out("idle_hold", 24'd0, 1'b0, 1'b0, 1'b0);
            check_out();
        end

        pulse(1'b1, 1'b0, 1'b0);
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tick) ticks++;
        end
        cmp("tick_count", 24'(ticks), 24'd100);
        expect_out("run_1s", bcd_of(100), 1'b1, 1'b0, 1'b0);
        check_out();

        pulse(1'b1, 1'b0, 1'b0);
        expect_out("pause_after_run", bcd_of(100), 1'b0, 1'b0, 1'b0);
        check_out();
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("clear_from_pause", 24'd0, 1'b0, 1'b0, 1'b0);
        check_out();

        pulse(1'b1, 1'b0, 1'b0);
        cycles(20);
        expect_out("run_10cs", bcd_of(10), 1'b1, 1'b0, 1'b0);
        check_out();
        pulse(1'b0, 1'b1, 1'b0);
        cycles(39);
        expect_out("lap_frozen", LAP_EN ? bcd_of(10) : bcd_of(30), 1'b1, LAP_EN, 1'b0);
        check_out();
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("lap_return", bcd_of(30), 1'b1, 1'b0, 1'b0);
        check_out();
        cmp("tick_phase", {23'd0, tick}, 24'd1);

        pulse(1'b1, 1'b0, 1'b0);
        expect_out("stop_on_tick", bcd_of(31), 1'b0, 1'b0, 1'b0);
        check_out();
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("clear_again", 24'd0, 1'b0, 1'b0, 1'b0);
        check_out();

        pulse(1'b1, 1'b0, 1'b0);
        cycles(10);
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("pause_5cs", bcd_of(5), 1'b0, 1'b0, 1'b0);
        check_out();
        cycles(5);
        expect_out("pause_hold", bcd_of(5), 1'b0, 1'b0, 1'b0);
        check_out();
        pulse(1'b1, 1'b1, 1'b1);
        expect_out("clear_wins", 24'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        cycles(4);
        expect_out("idle_after_clear", 24'd0, 1'b0, 1'b0, 1'b0);
        check_out();

        pulse(1'b1, 1'b0, 1'b0);
        budget = 10;
        while (!tick && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        cmp("tick_wait", {23'd0, tick}, 24'd1);
        force dut.u_cs_o.cnt  = 4'd9;
        force dut.u_cs_t.cnt  = 4'd9;
        force dut.u_sec_o.cnt = 4'd9;
        force dut.u_sec_t.cnt = 4'd5;
        force dut.u_min_o.cnt = 4'd9;
        force dut.u_min_t.cnt = 4'd5;
        #1;
        release dut.u_cs_o.cnt;
        release dut.u_cs_t.cnt;
        release dut.u_sec_o.cnt;
        release dut.u_sec_t.cnt;
        release dut.u_min_o.cnt;
        release dut.u_min_t.cnt;
        @(negedge clk);
        expect_out("wrap", 24'd0, 1'b1, 1'b0, 1'b1);
        check_out();
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("overflow_sticky", 24'd0, 1'b0, 1'b0, 1'b1);
        check_out();
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("clear_overflow", 24'd0, 1'b0, 1'b0, 1'b0);
        check_out();

        pulse(1'b1, 1'b0, 1'b0);
        cycles(5);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("lap_capture", LAP_EN ? bcd_of(2) : bcd_of(3), 1'b1, LAP_EN, 1'b0);
        check_out();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        expect_out("reset_in_lap", 24'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        cmp("reset_in_lap.tick", {23'd0, tick}, 24'd0);
        @(negedge clk);
        expect_out("post_reset_idle", 24'd0, 1'b0, 1'b0, 1'b0);
        check_out();

        pulse(1'b1, 1'b0, 1'b0);
        cmp("first_tick_lat0", {23'd0, tick}, 24'd0);
        @(negedge clk);
        cmp("first_tick_lat1", {23'd0, tick}, 24'd1);
        @(negedge clk);
        expect_out("first_digit", bcd_of(1), 1'b1, 1'b0, 1'b0);
        check_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
